serial_magnitude_comparator: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator. Successor to the 2-bit combinational

---
 rtl/serial_magnitude_comparator_if.sv | 25 ++
 rtl/serial_magnitude_comparator.sv | 166 ++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and operand/result bundle for serial_magnitude_comparator.
// The requester drives start and the operands; the comparator returns busy, done and the result.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: DIGIT bits per cycle, MSB slice first, optional early exit.
// gt/eq/lt are updated only with the one-cycle done pulse and held until the next done.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 2,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_magnitude_comparator_if.slave  bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_cfg_err
            $error("serial_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] bias_operand(input logic [WIDTH-1:0] value,
                                                      input logic             is_signed);
        logic [WIDTH-1:0] mask;
        mask = '0;
        mask[WIDTH-1] = is_signed;
        return value ^ mask;
    endfunction

    // Returns {greater, less} for one unsigned slice.
    function automatic logic [1:0] slice_order(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y);
        logic [1:0] res;
        if (x > y) begin
            res = 2'b10;
        end else if (x < y) begin
            res = 2'b01;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_gt_q, acc_gt_d;
    logic             acc_lt_q, acc_lt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [1:0]       slice_res_s;
    logic             decided_s;
    logic             new_gt_s;
    logic             new_lt_s;
    logic             last_s;
    logic             finish_s;

    // Decision for the slice currently at the top of the shifted operands.
    always_comb begin
        slice_res_s = slice_order(a_q[WIDTH-1 -: DIGIT], b_q[WIDTH-1 -: DIGIT]);
        decided_s   = acc_gt_q | acc_lt_q;
        new_gt_s    = decided_s ? acc_gt_q : slice_res_s[1];
        new_lt_s    = decided_s ? acc_lt_q : slice_res_s[0];
        last_s      = (cnt_q == CW'(N - 1));
        finish_s    = last_s | (EARLY_EXIT & (slice_res_s != 2'b00));
    end

    // Next-state, operand shifting and result update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_gt_d = acc_gt_q;
        acc_lt_d = acc_lt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    a_d      = bias_operand(bus.a, bus.signed_mode);
                    b_d      = bias_operand(bus.b, bus.signed_mode);
                    cnt_d    = '0;
                    acc_gt_d = 1'b0;
                    acc_lt_d = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            S_RUN: begin
                a_d      = a_q << DIGIT;
                b_d      = b_q << DIGIT;
                cnt_d    = cnt_q + CW'(1);
                acc_gt_d = new_gt_s;
                acc_lt_d = new_lt_s;
                if (finish_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    gt_d    = new_gt_s;
                    lt_d    = new_lt_s;
                    eq_d    = ~new_gt_s & ~new_lt_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any compare in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_gt_q <= 1'b0;
            acc_lt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_gt_q <= acc_gt_d;
            acc_lt_q <= acc_lt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: early-exit and full-scan builds side by side,
// checked every cycle against a latency/ordering model plus literal expectations.
module tb_serial_magnitude_comparator;

    localparam int W = 16;
    localparam int D = 2;
    localparam int N = W / D;

    logic         clk;
    logic         rst_n;
    logic         start_s;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         sm_s;

    int total = 0;
    int bad   = 0;

    serial_magnitude_comparator_if #(.WIDTH(W)) if_ee ();
    serial_magnitude_comparator_if #(.WIDTH(W)) if_full ();

    assign if_ee.start         = start_s;
    assign if_ee.a             = a_s;
    assign if_ee.b             = b_s;
    assign if_ee.signed_mode   = sm_s;
    assign if_full.start       = start_s;
    assign if_full.a           = a_s;
    assign if_full.b           = b_s;
    assign if_full.signed_mode = sm_s;

    serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b1)) dut_ee (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_ee)
    );

    serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b0)) dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles to done: first differing slice (MSB first) with early exit, else all slices.
    function automatic int latency(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
        logic [W-1:0] diff;
        if (!ee) return N;
        diff = x ^ y;
        for (int i = 0; i < N; i++) begin
            if (diff[W-1-i*D -: D] != '0) return i + 1;
        end
        return N;
    endfunction

    // {gt, eq, lt} from plain arithmetic comparison.
    function automatic logic [2:0] order(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        if (sm) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    // Model: index 0 = early-exit build, index 1 = full-scan build.
    logic       m_busy [2];
    logic       m_done [2];
    logic [2:0] m_res  [2];
    logic [2:0] m_pend [2];
    int         m_left [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_busy[u] <= 1'b0;
                m_done[u] <= 1'b0;
                m_res[u]  <= 3'b000;
                m_pend[u] <= 3'b000;
                m_left[u] <= 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_done[u] <= 1'b0;
                if (m_busy[u]) begin
                    m_left[u] <= m_left[u] - 1;
                    if (m_left[u] == 1) begin
                        m_busy[u] <= 1'b0;
                        m_done[u] <= 1'b1;
                        m_res[u]  <= m_pend[u];
                    end
                end else if (start_s) begin
                    m_busy[u] <= 1'b1;
                    m_left[u] <= latency(a_s, b_s, u == 0);
                    m_pend[u] <= order(a_s, b_s, sm_s);
                end
            end
        end
    end

    // Every-cycle comparison of both builds against the model.
    always @(negedge clk) begin
        chk("ee_busy",   {31'd0, if_ee.busy},   {31'd0, m_busy[0]});
        chk("ee_done",   {31'd0, if_ee.done},   {31'd0, m_done[0]});
        chk("ee_res",    {29'd0, if_ee.gt, if_ee.eq, if_ee.lt},       {29'd0, m_res[0]});
        chk("full_busy", {31'd0, if_full.busy}, {31'd0, m_busy[1]});
        chk("full_done", {31'd0, if_full.done}, {31'd0, m_done[1]});
        chk("full_res",  {29'd0, if_full.gt, if_full.eq, if_full.lt}, {29'd0, m_res[1]});
    end

    // Called just after the accepting edge; waits (bounded) for both done pulses.
    task automatic wait_done(input logic [2:0] exp_res, input int exp_k_ee, input string tag);
        int k_ee   = 0;
        int k_full = 0;
        for (int c = 1; c <= 40 && (k_ee == 0 || k_full == 0); c++) begin
            @(posedge clk);
            #1;
            if (if_ee.done && k_ee == 0) begin
                k_ee = c;
                chk({tag, "_ee_flags"}, {29'd0, if_ee.gt, if_ee.eq, if_ee.lt}, {29'd0, exp_res});
                chk({tag, "_model_flags"}, {29'd0, m_res[0]}, {29'd0, exp_res});
            end
            if (if_full.done && k_full == 0) begin
                k_full = c;
                chk({tag, "_full_flags"}, {29'd0, if_full.gt, if_full.eq, if_full.lt}, {29'd0, exp_res});
            end
        end
        chk({tag, "_ee_latency"}, k_ee, exp_k_ee);
        chk({tag, "_full_latency"}, k_full, N);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input logic [2:0] exp_res, input int exp_k_ee, input string tag);
        a_s     = a;
        b_s     = b;
        sm_s    = sm;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        chk({tag, "_busy_e0"}, {30'd0, if_ee.busy, if_full.busy}, 32'd3);
        wait_done(exp_res, exp_k_ee, tag);
    endtask

    initial begin
        int c;
        rst_n   = 1'b1;
        start_s = 1'b0;
        a_s     = 16'h0000;
        b_s     = 16'h0000;
        sm_s    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {22'd0, if_ee.busy, if_ee.done, if_ee.gt, if_ee.eq, if_ee.lt,
                              if_full.busy, if_full.done, if_full.gt, if_full.eq, if_full.lt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(16'h1234, 16'h1234, 1'b0, 3'b010, 8, "t1_equal");
        run(16'h8000, 16'h7FFF, 1'b0, 3'b100, 1, "t2_uns");
        run(16'h8000, 16'h7FFF, 1'b1, 3'b001, 1, "t2_sgn");
        run(16'h0001, 16'h0002, 1'b0, 3'b001, 8, "t3_uns");
        run(16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 8, "t3_sgn");
        run(16'h00F0, 16'h00E0, 1'b0, 3'b100, 6, "mid_slice");
        run(16'h8000, 16'h8000, 1'b1, 3'b010, 8, "sgn_equal");

        // Start held through busy with operands changing every cycle.
        a_s     = 16'h1234;
        b_s     = 16'h1234;
        sm_s    = 1'b0;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        c = 0;
        while (!if_ee.done && c < 40) begin
            a_s = a_s ^ 16'hA5C3 ^ 16'(c);
            b_s = b_s + 16'h0F01;
            sm_s = ~sm_s;
            @(posedge clk);
            #1;
            c++;
        end
        chk("t4_hold_latency", c, 8);
        chk("t4_hold_flags", {29'd0, if_ee.gt, if_ee.eq, if_ee.lt}, 32'd2);
        a_s  = 16'h0005;
        b_s  = 16'h0003;
        sm_s = 1'b0;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        chk("t4_b2b_busy", {30'd0, if_ee.busy, if_full.busy}, 32'd3);
        wait_done(3'b100, 7, "t4_b2b");

        // Reset in the middle of a compare.
        a_s     = 16'h1234;
        b_s     = 16'h1234;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_abort_outputs", {22'd0, if_ee.busy, if_ee.done, if_ee.gt, if_ee.eq, if_ee.lt,
                                 if_full.busy, if_full.done, if_full.gt, if_full.eq, if_full.lt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_done", {30'd0, if_ee.done, if_full.done}, 32'd0);
        run(16'h00F0, 16'h00E0, 1'b0, 3'b100, 6, "t5_fresh");

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
